// File: rtl/fwd_hazard_unit.sv
// Operand forwarding and load-use hazard detection for a 5-stage pipeline.
// Optional stall counter output enabled by defining FWD_HAZARD_STALL_CNT_EN.
module fwd_hazard_unit (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       id_valid_i,
  input  logic [4:0] id_rs_i,
  input  logic [4:0] id_rt_i,
  input  logic [4:0] id_rd_i,
  input  logic       id_regwrite_i,
  input  logic       id_memread_i,
  input  logic       flush_i,
`ifdef FWD_HAZARD_STALL_CNT_EN
  output logic [31:0] stall_cnt_o,
`endif
  output logic [1:0] forward_a_o,
  output logic [1:0] forward_b_o,
  output logic       stall_o
);

  typedef struct packed {
    logic       valid;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic       regwrite;
    logic       memread;
  } ex_rec_t;

  typedef struct packed {
    logic [4:0] rd;
    logic       regwrite;
  } wr_rec_t;

  ex_rec_t ex_q;
  wr_rec_t mem_q;
  wr_rec_t wb_q;
  logic    load_use;
  logic    bubble;

  function automatic logic [1:0] fwd_sel(input logic [4:0] src,
                                          input wr_rec_t mem_r,
                                          input wr_rec_t wb_r);
    logic [1:0] sel;
    sel = 2'd0;
    if (mem_r.regwrite && (mem_r.rd != '0) && (mem_r.rd == src))
      sel = 2'd1;
    else if (wb_r.regwrite && (wb_r.rd != '0) && (wb_r.rd == src))
      sel = 2'd2;
    return sel;
  endfunction

  always_comb begin
    load_use = id_valid_i && ex_q.memread && (ex_q.rd != '0) &&
               ((ex_q.rd == id_rs_i) || (ex_q.rd == id_rt_i));
    stall_o  = load_use && !flush_i && !rst_i;
    bubble   = flush_i || !id_valid_i || load_use;
  end

  // Reset and EX bubbles mask forwarding regardless of stale rs/rt contents.
  always_comb begin
    forward_a_o = 2'd0;
    forward_b_o = 2'd0;
    if (!rst_i && ex_q.valid) begin
      forward_a_o = fwd_sel(ex_q.rs, mem_q, wb_q);
      forward_b_o = fwd_sel(ex_q.rt, mem_q, wb_q);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else begin
      wb_q  <= mem_q;
      mem_q <= '{rd: ex_q.rd, regwrite: ex_q.regwrite};
      if (bubble)
        ex_q <= '0;
      else
        ex_q <= '{valid: 1'b1, rs: id_rs_i, rt: id_rt_i, rd: id_rd_i,
                  regwrite: id_regwrite_i, memread: id_memread_i};
    end
  end

`ifdef FWD_HAZARD_STALL_CNT_EN
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i)
      stall_cnt_q <= '0;
    else if (stall_o)
      stall_cnt_q <= stall_cnt_q + 32'd1;
  end

  assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Self-checking bench for fwd_hazard_unit: directed scenarios plus random
// traffic compared against an instruction-level pipeline model.
module tb_fwd_hazard_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid;
  logic [4:0] id_rs, id_rt, id_rd;
  logic       id_rw, id_mr;
  logic       flush;
  logic [1:0] fwd_a, fwd_b;
  logic       stall;
`ifdef FWD_HAZARD_STALL_CNT_EN
  logic [31:0] stall_cnt;
  logic [31:0] cnt_exp = 32'd0;
`endif

  int checks   = 0;
  int failures = 0;

  typedef struct {
    bit valid;
    int rs;
    int rt;
    int rd;
    bit rw;
    bit mr;
  } ins_t;

  // pipe[0]=EX, pipe[1]=MEM, pipe[2]=WB
  ins_t pipe [3];

  fwd_hazard_unit dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .id_valid_i   (id_valid),
    .id_rs_i      (id_rs),
    .id_rt_i      (id_rt),
    .id_rd_i      (id_rd),
    .id_regwrite_i(id_rw),
    .id_memread_i (id_mr),
    .flush_i      (flush),
`ifdef FWD_HAZARD_STALL_CNT_EN
    .stall_cnt_o  (stall_cnt),
`endif
    .forward_a_o  (fwd_a),
    .forward_b_o  (fwd_b),
    .stall_o      (stall)
  );

  always #5 clk = ~clk;

  function automatic ins_t nop();
    ins_t b;
    b.valid = 0; b.rs = 0; b.rt = 0; b.rd = 0; b.rw = 0; b.mr = 0;
    return b;
  endfunction

  // Youngest in-flight writer of src wins; distance 1 = MEM, 2 = WB.
  function automatic int exp_fwd(int src);
    if (rst || !pipe[0].valid) return 0;
    for (int j = 1; j <= 2; j++)
      if (pipe[j].rw && pipe[j].rd != 0 && pipe[j].rd == src) return j;
    return 0;
  endfunction

  function automatic bit exp_stall();
    return !rst && id_valid && !flush && pipe[0].mr && pipe[0].rd != 0 &&
           (pipe[0].rd == int'(id_rs) || pipe[0].rd == int'(id_rt));
  endfunction

  task automatic check(string tag, int obs, int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One cycle: drive ID slot, check at negedge against model and optional
  // directed constants (-1 = not checked), then advance the model at posedge.
  task automatic step(bit r, bit v, int rs, int rt, int rd, bit rw, bit mr,
                      bit fl, int ka = -1, int kb = -1, int ks = -1);
    bit   st;
    ins_t n;
    rst = r; id_valid = v; id_rs = 5'(rs); id_rt = 5'(rt); id_rd = 5'(rd);
    id_rw = rw; id_mr = mr; flush = fl;
    @(negedge clk);
    st = exp_stall();
    check("fwd_a", int'(fwd_a), exp_fwd(int'(id_rs) >= 0 ? pipe[0].rs : 0));
    check("fwd_b", int'(fwd_b), exp_fwd(pipe[0].rt));
    check("stall", int'(stall), int'(st));
    if (ka >= 0) check("fwd_a_dir", int'(fwd_a), ka);
    if (kb >= 0) check("fwd_b_dir", int'(fwd_b), kb);
    if (ks >= 0) check("stall_dir", int'(stall), ks);
`ifdef FWD_HAZARD_STALL_CNT_EN
    check("stall_cnt", int'(stall_cnt), int'(cnt_exp));
`endif
    @(posedge clk);
    if (r) begin
      pipe[0] = nop(); pipe[1] = nop(); pipe[2] = nop();
`ifdef FWD_HAZARD_STALL_CNT_EN
      cnt_exp = 32'd0;
`endif
    end else begin
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      if (fl || !v || st) pipe[0] = nop();
      else begin
        n.valid = 1; n.rs = rs; n.rt = rt; n.rd = rd; n.rw = rw; n.mr = mr;
        pipe[0] = n;
      end
`ifdef FWD_HAZARD_STALL_CNT_EN
      if (st) cnt_exp = cnt_exp + 32'd1;
`endif
    end
    #1;
  endtask

  task automatic idle(int ka = -1, int kb = -1, int ks = -1);
    step(0, 0, 0, 0, 0, 0, 0, 0, ka, kb, ks);
  endtask

  initial begin
    bit r, v, fl, held;
    int rs, rt, rd;
    bit rw, mr;
    pipe[0] = nop(); pipe[1] = nop(); pipe[2] = nop();
    rst = 1; id_valid = 0; id_rs = 0; id_rt = 0; id_rd = 0;
    id_rw = 0; id_mr = 0; flush = 0;
    @(posedge clk); #1;

    // Reset held two cycles with random inputs, then idle
    repeat (2)
      step(1, 1'($urandom), $urandom_range(31), $urandom_range(31),
           $urandom_range(31), 1'($urandom), 1'($urandom), 1'($urandom),
           0, 0, 0);
    idle(0, 0, 0);

    // add $3 ; sub rs=$3 ; or rt=$3
    step(0, 1, 1, 2, 3, 1, 0, 0);
    step(0, 1, 3, 4, 6, 1, 0, 0);
    step(0, 1, 8, 3, 9, 1, 0, 0, 1, -1, 0);
    idle(-1, 2, 0);
    idle(); idle();

    // lw $5 ; add rt=$5 (held one cycle by stall)
    step(0, 1, 1, 0, 5, 1, 1, 0);
    step(0, 1, 2, 5, 10, 1, 0, 0, -1, -1, 1);
    step(0, 1, 2, 5, 10, 1, 0, 0, 0, 0, 0);
    idle(0, 2, 0);
    idle(); idle();

    // two writes to $7 then reader -> MEM priority
    step(0, 1, 1, 2, 7, 1, 0, 0);
    step(0, 1, 3, 4, 7, 1, 0, 0);
    step(0, 1, 7, 7, 11, 1, 0, 0);
    idle(1, 1, 0);
    // writes to $0 never forward
    step(0, 1, 1, 2, 0, 1, 0, 0);
    step(0, 1, 0, 0, 12, 1, 0, 0);
    idle(0, 0, 0);
    idle(); idle();

    // lw $5 ; dependent flushed in the same cycle
    step(0, 1, 1, 0, 5, 1, 1, 0);
    step(0, 1, 5, 5, 13, 1, 0, 1, -1, -1, 0);
    idle(0, 0, 0);
    idle(); idle();

    // reset mid-stall drops the stall and clears records
    step(0, 1, 1, 0, 5, 1, 1, 0);
    step(1, 1, 5, 0, 14, 1, 0, 0, 0, 0, 0);
    step(0, 1, 5, 0, 14, 1, 0, 0, 0, 0, 0);
    idle(0, 0, 0);

`ifdef FWD_HAZARD_STALL_CNT_EN
    // counter wrap: deposit all-ones then one stall
    idle(); idle();
    step(0, 1, 1, 0, 5, 1, 1, 0);
    dut.stall_cnt_q = 32'hFFFF_FFFF;
    cnt_exp = 32'hFFFF_FFFF;
    step(0, 1, 5, 0, 15, 1, 0, 0, -1, -1, 1);
    idle();
    check("stall_cnt_wrap", int'(stall_cnt), 0);
`endif

    // Random traffic; a stalled instruction is re-presented like a held IF/ID
    held = 0;
    rs = 0; rt = 0; rd = 0; rw = 0; mr = 0; v = 0;
    for (int i = 0; i < 400; i++) begin
      r  = ($urandom_range(39) == 0);
      fl = ($urandom_range(7) == 0);
      if (!held) begin
        v  = ($urandom_range(7) != 0);
        rs = $urandom_range(7); rt = $urandom_range(7); rd = $urandom_range(7);
        rw = 1'($urandom); mr = rw && ($urandom_range(2) == 0);
      end
      rst = r; id_valid = v; id_rs = 5'(rs); id_rt = 5'(rt); flush = fl;
      held = exp_stall();
      step(r, v, rs, rt, rd, rw, mr, fl);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL timeout observed=running expected=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
